// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, instruction SRAM request, pending-redirect buffer and fetch counter.
// Optional fetch alignment check compiled in with `define IF_ADDR_CHECK_EN.
`ifndef StallBus
`define StallBus 6
`endif
`ifndef BR_WD
`define BR_WD 33
`endif
`ifndef IF_TO_ID_WD
`define IF_TO_ID_WD 33
`endif
`ifndef Stop
`define Stop 1'b1
`endif

module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [`StallBus-1:0]    stall,
  input  logic [`BR_WD-1:0]       br_bus,
  output logic [`IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                    inst_sram_en,
  output logic [3:0]              inst_sram_wen,
  output logic [31:0]             inst_sram_addr,
  output logic [31:0]             inst_sram_wdata,
  output logic [31:0]             fetch_cnt,
  output logic                    fetch_adel
);

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic [31:0] cnt;
  logic [31:0] next_pc;
  logic        advance;
  logic        count_en;
  logic        stall_unused;

  assign {br_e, br_addr} = br_bus;
  assign advance         = (stall[0] != `Stop);
  // Only the PC-stage stall bit matters here; the IF/ID bit belongs to decode.
  assign stall_unused    = ^stall[`StallBus-1:1];

  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br_e)        next_pc = br_addr;
    else if (pend_v) next_pc = pend_addr;
  end

`ifdef IF_ADDR_CHECK_EN
  logic misalign;
  logic adel_r;

  assign misalign     = ce_reg && (pc_reg[1:0] != 2'b00);
  assign count_en     = ce_reg && !misalign;
  assign inst_sram_en = ce_reg && !misalign;
  // Flag is visible in the same cycle the bad fetch is suppressed, then held.
  assign fetch_adel   = adel_r | misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           adel_r <= 1'b0;
    else if (misalign) adel_r <= 1'b1;
  end
`else
  assign count_en     = ce_reg;
  assign inst_sram_en = ce_reg;
  assign fetch_adel   = 1'b0;
`endif

  // A redirect arriving during a hold is parked; the live one wins on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      ce_reg    <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      cnt       <= '0;
    end else if (advance) begin
      pc_reg <= next_pc;
      ce_reg <= 1'b1;
      pend_v <= 1'b0;
      if (count_en) cnt <= cnt + 32'd1;
    end else if (br_e) begin
      pend_v    <= 1'b1;
      pend_addr <= br_addr;
    end
  end

  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wen   = '0;
  assign inst_sram_wdata = '0;
  assign fetch_cnt       = cnt;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a reference model pushes expected outputs per driven cycle, tasks pop and compare.
module tb_if_fetch;

`ifdef IF_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] fetch_cnt;
  logic        fetch_adel;

  if_fetch #(.RESET_PC(32'hBFBF_FFFC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .if_to_id_bus(if_to_id_bus), .inst_sram_en(inst_sram_en),
    .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .fetch_cnt(fetch_cnt),
    .fetch_adel(fetch_adel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        en;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic        m_ce, m_pend_v, m_adel;
  logic [31:0] m_pc, m_pend_addr, m_cnt;

  task automatic model_reset();
    m_pc = 32'hBFBF_FFFC; m_ce = 1'b0; m_pend_v = 1'b0;
    m_pend_addr = '0; m_cnt = '0; m_adel = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus and push the expected post-edge outputs.
  task automatic drive(input logic s0, input logic be, input logic [31:0] ba);
    exp_t e;
    logic mis;
    stall  = {5'($urandom), s0};
    br_bus = {be, ba};
    mis = CHK && m_ce && (m_pc[1:0] != 2'b00);
    if (mis) m_adel = 1'b1;
    if (!s0) begin
      m_pc = be ? ba : (m_pend_v ? m_pend_addr : m_pc + 32'd4);
      if (m_ce && !mis) m_cnt = m_cnt + 32'd1;
      m_ce = 1'b1;
      m_pend_v = 1'b0;
    end else if (be) begin
      m_pend_v = 1'b1;
      m_pend_addr = ba;
    end
    e.ce   = m_ce;
    e.pc   = m_pc;
    e.cnt  = m_cnt;
    e.en   = m_ce && !(CHK && m_pc[1:0] != 2'b00);
    e.adel = m_adel || (CHK && m_ce && m_pc[1:0] != 2'b00);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = '0;
    br_bus = '0;
    model_reset();
    #2;
    checks++;
    if ({if_to_id_bus, inst_sram_en, fetch_cnt, fetch_adel} !== {1'b0, 32'hBFBF_FFFC, 1'b0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got bus=%h en=%b cnt=%h adel=%b want bus=0bfbffffc en=0 cnt=0 adel=0",
               if_to_id_bus, inst_sram_en, fetch_cnt, fetch_adel);
    end
    checks++;
    if ({inst_sram_wen, inst_sram_wdata} !== 36'd0) begin
      errors++;
      $display("FAIL sram_write_tie got wen=%h wdata=%h want 0/0", inst_sram_wen, inst_sram_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({if_to_id_bus, fetch_cnt, inst_sram_en, fetch_adel} !== {e.ce, e.pc, e.cnt, e.en, e.adel}) begin
        errors++;
        $display("FAIL basic_model got bus=%h cnt=%h en=%b adel=%b want bus=%h cnt=%h en=%b adel=%b",
                 if_to_id_bus, fetch_cnt, inst_sram_en, fetch_adel, {e.ce, e.pc}, e.cnt, e.en, e.adel);
      end
      checks++;
      if (inst_sram_addr !== 32'hBFC0_0000 + 32'(4 * i)) begin
        errors++;
        $display("FAIL basic_addr%0d got %h want %h", i, inst_sram_addr, 32'hBFC0_0000 + 32'(4 * i));
      end
    end
    checks++;
    if (fetch_cnt !== 32'd2) begin
      errors++;
      $display("FAIL basic_cnt got %0d want 2", fetch_cnt);
    end
  endtask

  task automatic test_delay_slot();
    exp_t e;
    drive(1'b0, 1'b0, '0); @(posedge clk); #1; void'(exp_q.pop_front());
    drive(1'b0, 1'b0, '0); @(posedge clk); #1; e = exp_q.pop_front();
    checks++;
    if (inst_sram_addr !== 32'hBFC0_0010 || e.pc !== 32'hBFC0_0010) begin
      errors++;
      $display("FAIL slot_pc got %h want bfc00010", inst_sram_addr);
    end
    drive(1'b0, 1'b1, 32'hBFC0_0100); @(posedge clk); #1; e = exp_q.pop_front();
    checks++;
    if ({if_to_id_bus, fetch_cnt} !== {e.ce, e.pc, e.cnt} || inst_sram_addr !== 32'hBFC0_0100) begin
      errors++;
      $display("FAIL slot_redirect got bus=%h cnt=%h want bus=%h cnt=%h", if_to_id_bus, fetch_cnt, {e.ce, e.pc}, e.cnt);
    end
    br_bus = '0;
  endtask

  task automatic test_stalled_redirect();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 0, 32'hBFC0_0200);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({if_to_id_bus, fetch_cnt} !== {e.ce, e.pc, e.cnt} || inst_sram_addr !== 32'hBFC0_0100) begin
        errors++;
        $display("FAIL stall_hold%0d got bus=%h cnt=%h want bus=%h cnt=%h", i, if_to_id_bus, fetch_cnt, {e.ce, e.pc}, e.cnt);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, '0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({if_to_id_bus, fetch_cnt} !== {e.ce, e.pc, e.cnt} || inst_sram_addr !== 32'hBFC0_0200 + 32'(4 * i)) begin
        errors++;
        $display("FAIL stall_release%0d got bus=%h cnt=%h want bus=%h cnt=%h", i, if_to_id_bus, fetch_cnt, {e.ce, e.pc}, e.cnt);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    drive(1'b1, 1'b1, 32'hBFC0_0200); @(posedge clk); #1; void'(exp_q.pop_front());
    drive(1'b0, 1'b1, 32'hBFC0_0300); @(posedge clk); #1; e = exp_q.pop_front();
    checks++;
    if (if_to_id_bus !== {e.ce, e.pc} || inst_sram_addr !== 32'hBFC0_0300) begin
      errors++;
      $display("FAIL simul_live got pc=%h want bfc00300", inst_sram_addr);
    end
    drive(1'b1, 1'b1, 32'hBFC0_0400); @(posedge clk); #1; void'(exp_q.pop_front());
    drive(1'b1, 1'b1, 32'hBFC0_0480); @(posedge clk); #1; void'(exp_q.pop_front());
    drive(1'b0, 1'b0, '0); @(posedge clk); #1; e = exp_q.pop_front();
    checks++;
    if (if_to_id_bus !== {e.ce, e.pc} || inst_sram_addr !== 32'hBFC0_0480) begin
      errors++;
      $display("FAIL last_wins got pc=%h want bfc00480", inst_sram_addr);
    end
  endtask

  task automatic test_alignment();
    exp_t e;
    drive(1'b0, 1'b1, 32'hBFC0_0402); @(posedge clk); #1; e = exp_q.pop_front();
    checks++;
    if ({inst_sram_en, fetch_adel} !== {e.en, e.adel} || {inst_sram_en, fetch_adel} !== (CHK ? 2'b01 : 2'b10)) begin
      errors++;
      $display("FAIL align_bad got en=%b adel=%b want en=%b adel=%b", inst_sram_en, fetch_adel, e.en, e.adel);
    end
    drive(1'b0, 1'b1, 32'hBFC0_0500); @(posedge clk); #1; e = exp_q.pop_front();
    checks++;
    if ({if_to_id_bus, fetch_cnt, inst_sram_en, fetch_adel} !== {e.ce, e.pc, e.cnt, e.en, e.adel}
        || fetch_adel !== CHK) begin
      errors++;
      $display("FAIL align_sticky got bus=%h cnt=%h en=%b adel=%b want bus=%h cnt=%h en=%b adel=%b",
               if_to_id_bus, fetch_cnt, inst_sram_en, fetch_adel, {e.ce, e.pc}, e.cnt, e.en, e.adel);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    force dut.pc_reg = 32'hFFFF_FFFC;
    force dut.cnt = 32'hFFFF_FFFF;
    #1;
    release dut.pc_reg;
    release dut.cnt;
    m_pc = 32'hFFFF_FFFC;
    m_cnt = 32'hFFFF_FFFF;
    checks++;
    if (inst_sram_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_preload got %h want fffffffc", inst_sram_addr);
    end
    drive(1'b0, 1'b0, '0); @(posedge clk); #1; e = exp_q.pop_front();
    checks++;
    if ({inst_sram_addr, fetch_cnt} !== {e.pc, e.cnt} || {inst_sram_addr, fetch_cnt} !== 64'd0) begin
      errors++;
      $display("FAIL wrap got pc=%h cnt=%h want pc=00000000 cnt=00000000", inst_sram_addr, fetch_cnt);
    end
  endtask

  task automatic test_reset_mid_hold();
    exp_t e;
    drive(1'b1, 1'b1, 32'hBFC0_0600); @(posedge clk); #1; void'(exp_q.pop_front());
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({if_to_id_bus, inst_sram_en, fetch_cnt, fetch_adel} !== {1'b0, 32'hBFBF_FFFC, 1'b0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got bus=%h en=%b cnt=%h adel=%b want bus=0bfbffffc en=0 cnt=0 adel=0",
               if_to_id_bus, inst_sram_en, fetch_cnt, fetch_adel);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, '0); @(posedge clk); #1; e = exp_q.pop_front();
    checks++;
    if ({if_to_id_bus, fetch_cnt} !== {e.ce, e.pc, e.cnt} || if_to_id_bus !== {1'b1, 32'hBFC0_0000}) begin
      errors++;
      $display("FAIL reset_discard got bus=%h cnt=%h want bus=1bfc00000 cnt=0", if_to_id_bus, fetch_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_delay_slot();
    test_stalled_redirect();
    test_simultaneous();
    test_alignment();
    test_wrap();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage MIPS pipeline.
- Owns the PC register and drives the instruction SRAM request.
- Produces `if_to_id_bus` `{ce, pc}` for the decode stage, and consumes that stage's `br_bus` redirect and the global `stall` bus.
- Holds a one-entry pending-redirect register, so a branch resolved while fetch is stalled is not lost.
- Keeps a fetched-instruction counter.

## Interface
Parameters:
- `RESET_PC`, default 32'hBFBF_FFFC: PC value held in reset. The first fetched address is `RESET_PC` + 4 = 32'hBFC0_0000.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `stall`  in  `` `StallBus ``  stall vector; bit 0 = PC stage, bit 1 = IF/ID register. `` `Stop `` = 1.
- `br_bus`  in  `` `BR_WD `` (33)  `{br_e, br_addr}` from decode.
- `if_to_id_bus`  out  `` `IF_TO_ID_WD `` (33)  `{ce, pc}`.
- `inst_sram_en`  out  1  SRAM read enable.
- `inst_sram_wen`  out  4  always 4'b0000.
- `inst_sram_addr`  out  32  SRAM address = current PC.
- `inst_sram_wdata`  out  32  always 32'b0.
- `fetch_cnt`  out  32  count of accepted fetches.
- `fetch_adel`  out  1  sticky fetch address error (see Configuration).

## Operation
- State:
  - `pc_reg[31:0]`, `ce_reg`
  - `pend_v`, `pend_addr[31:0]`
  - `cnt[31:0]`
  - `adel_r`
- Outputs:
  - `if_to_id_bus` = `{ce_reg, pc_reg}`
  - `inst_sram_addr` = `pc_reg`
  - `inst_sram_en` = `ce_reg`, gated per Configuration.
- `next_pc` priority:
  1. `br_e` → `br_addr`
  2. `pend_v` → `pend_addr`
  3. otherwise `pc_reg` + 4 (32-bit, wraps modulo 2^32).
- Advance (edge with `stall[0]` == 0): `pc_reg` <= `next_pc`; `ce_reg` <= 1; `pend_v` <= 0.
- Hold (edge with `stall[0]` == 1): `pc_reg`/`ce_reg` unchanged; the SRAM re-reads the same address.
  - If `br_e` is high, `pend_v` <= 1 and `pend_addr` <= `br_addr`.
  - A later `br_e` during the same hold overwrites the pending entry; last one wins.
- Delay slot: `br_e` is seen while `pc_reg` holds the slot address (branch PC + 4). The slot is fetched normally and the redirect takes effect at the next advance.
- Counter: `cnt` increments on every advance edge with `ce_reg` == 1. It wraps from FFFF_FFFF to 0.
- Reset, asserted at any time including mid-hold: all state clears immediately without waiting for a clock. Any pending redirect is discarded.

## Timing
- Reset values:
  - `pc_reg` = `RESET_PC`, `ce_reg` = 0, so `if_to_id_bus` = {0, BFBF_FFFC}.
  - `inst_sram_en` = 0, `pend_v` = 0, `fetch_cnt` = 0, `fetch_adel` = 0.
- First edge after reset release with no stall: `pc_reg` = BFC0_0000 and `ce_reg` = 1.
- SRAM read latency is 1 cycle. Data for `pc_reg` at cycle t is valid at t+1, aligned with decode's registered copy of `if_to_id_bus`.
- Redirect latency:
  - `br_e` at cycle t with no stall → `pc_reg` = target at t+1.
  - With `stall[0]` held for cycles t..t+k → target at the first edge after stall release.
- `br_e` and stall release on the same edge: the live `br_addr` is used and `pend_v` clears.

## Configuration
- Macro: `IF_ADDR_CHECK_EN`.
- Defined:
  - When `ce_reg` == 1 and `pc_reg[1:0]` != 0, `inst_sram_en` is forced to 0.
  - `adel_r` sets on that condition and stays set until reset.
  - The counter does not increment for a misaligned fetch.
- Undefined:
  - `fetch_adel` is tied to 0.
  - `inst_sram_en` = `ce_reg`.
  - No alignment logic is compiled in.

## Test plan
- Reset:
  - Assert `rst` asynchronously mid-cycle → outputs go to reset values before the next edge.
  - Release, no stall, 3 edges → `inst_sram_addr` = BFC0_0000, BFC0_0004, BFC0_0008; `fetch_cnt` = 2 after the third edge.
- Delay-slot redirect: at `pc_reg` = BFC0_0010, drive `br_e` = 1 with `br_addr` = BFC0_0100 for one cycle → next `pc_reg` = BFC0_0100.
- Stalled redirect:
  - Hold `stall[0]` = 1 for 3 cycles and pulse `br_e` (BFC0_0200) in the first of them → `pc_reg` unchanged throughout.
  - Release → `pc_reg` = BFC0_0200 after one edge; `pend_v` = 0.
- Simultaneous events: `br_e` = 1 (BFC0_0300) on the release edge while a pending BFC0_0200 exists → `pc_reg` = BFC0_0300.
- Wrap: force `pc_reg` = FFFF_FFFC and `cnt` = FFFF_FFFF, advance → `pc_reg` = 0000_0000 and `fetch_cnt` = 0.
- Alignment (`IF_ADDR_CHECK_EN` defined): `br_addr` = BFC0_0402 → next cycle `inst_sram_en` = 0 and `fetch_adel` = 1, staying 1 after a later aligned redirect. With the macro undefined → `inst_sram_en` = 1 and `fetch_adel` = 0.
